// File: rtl/mem_pkg.sv
// Shared memory-subsystem definitions: arbiter state encoding, default
// command timeout and the address-map constants.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DATA = 2'd3
    } arb_state_t;

    localparam logic [7:0]  TIMEOUT_DEFAULT = 8'd200;

    localparam logic [15:0] VGA_BASE   = 16'h1000;
    localparam logic [15:0] SDRAM_BASE = 16'h4c00;

endpackage

// File: rtl/sdram_arbiter_rr_grant.sv
// Two-requester picker. With round-robin enabled a contended grant goes to
// the requester that did not win last; otherwise requester 0 always wins.
module rr_grant (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic rr_en,
    input  logic take,
    output logic pick
);

    logic last_grant;

    // Choose the winner from current requests and the previous winner.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = rr_en & ~last_grant;
        end else begin
            pick = ~req0;
        end
    end

    // Remember who won when the grant is actually taken; reset favours port 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (take) begin
            last_grant <= pick;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port SDRAM arbiter: CPU (port 0) and DMA/video (port 1) share one
// SDRAM controller command interface, with a per-transaction timeout.
module sdram_arbiter
    import mem_pkg::*;
#(
    parameter bit         RR_EN   = 1'b1,
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        cpu_clk,
    input  logic        rst,
    input  logic        p0_read,
    input  logic        p0_write,
    input  logic [22:0] p0_addr,
    input  logic [15:0] p0_wdata,
    output logic [15:0] p0_rdata,
    output logic        p0_busy,
    output logic        p0_ready,
    output logic        p0_cack,
    input  logic        p1_read,
    input  logic        p1_write,
    input  logic [22:0] p1_addr,
    input  logic [15:0] p1_wdata,
    output logic [15:0] p1_rdata,
    output logic        p1_busy,
    output logic        p1_ready,
    output logic        p1_cack,
    output logic        sdram_read,
    output logic        sdram_write,
    output logic [22:0] sdram_addr,
    output logic [15:0] sdram_wdata,
    input  logic        sdram_busy,
    input  logic        sdram_ready,
    input  logic        sdram_cack,
    input  logic [31:0] sdram_rdata,
    output logic        err_timeout
);

    arb_state_t  state, state_d;
    logic        gnt, op_read;
    logic [22:0] addr_q;
    logic [15:0] wdata_q;
    logic [7:0]  cnt;
    logic        err_q;
    logic        req0, req1, pick;
    logic        grant_fire, tmo, in_cmd, ack_fire, data_done, abort;
    logic        unused_rdata_hi;

    assign req0            = p0_read | p0_write;
    assign req1            = p1_read | p1_write;
    assign sdram_addr      = addr_q;
    assign sdram_wdata     = wdata_q;
    assign err_timeout     = err_q;
    assign unused_rdata_hi = ^sdram_rdata[31:16];

    rr_grant u_rr_grant (
        .clk   (cpu_clk),
        .rst   (rst),
        .req0  (req0),
        .req1  (req1),
        .rr_en (RR_EN),
        .take  (grant_fire),
        .pick  (pick)
    );

    // State register.
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state plus the command, handshake and busy outputs.
    always_comb begin
        state_d     = state;
        grant_fire  = 1'b0;
        tmo         = 1'b0;
        abort       = 1'b0;
        data_done   = 1'b0;
        in_cmd      = (state == ST_ISSUE) || (state == ST_WAIT_ACK);
        sdram_read  = 1'b0;
        sdram_write = 1'b0;

        if ((state == ST_WAIT_ACK) || (state == ST_WAIT_DATA)) begin
            tmo = (cnt == TIMEOUT - 8'd1);
        end

        unique case (state)
            ST_IDLE: begin
                grant_fire = !sdram_busy && (req0 || req1);
                if (grant_fire) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (sdram_cack) begin
                    state_d = op_read ? ST_WAIT_DATA : ST_IDLE;
                end else if (tmo) begin
                    state_d = ST_IDLE;
                    abort   = 1'b1;
                end
            end
            ST_WAIT_DATA: begin
                data_done = sdram_ready || tmo;
                abort     = !sdram_ready && tmo;
                if (data_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Command drops in the very cycle the controller accepts it.
        if ((state == ST_ISSUE) || ((state == ST_WAIT_ACK) && !sdram_cack)) begin
            sdram_read  = op_read;
            sdram_write = !op_read;
        end

        // Combinational so a requester can drop its request before IDLE re-arbitrates.
        ack_fire = (state == ST_WAIT_ACK) && (sdram_cack || tmo) && !rst;
        p0_cack  = ack_fire && !gnt;
        p1_cack  = ack_fire && gnt;

        p0_busy = sdram_busy || ((state != ST_IDLE) && gnt) || (in_cmd && !gnt);
        p1_busy = sdram_busy || ((state != ST_IDLE) && !gnt) || (in_cmd && gnt);
    end

    // Latch the winning port's request at grant time.
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            gnt     <= 1'b0;
            op_read <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_fire) begin
            gnt     <= pick;
            op_read <= pick ? p1_read : p0_read;
            addr_q  <= pick ? p1_addr : p0_addr;
            wdata_q <= pick ? p1_wdata : p0_wdata;
        end
    end

    // Timeout counter restarts on every state change and counts while waiting.
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state_d != state) begin
            cnt <= '0;
        end else if ((state == ST_WAIT_ACK) || (state == ST_WAIT_DATA)) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Sticky abort flag.
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (abort) begin
            err_q <= 1'b1;
        end
    end

    // Registered read return; a timed-out read pulses ready but keeps old data.
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            p0_ready <= 1'b0;
            p1_ready <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            p0_ready <= data_done && !gnt;
            p1_ready <= data_done && gnt;
            if ((state == ST_WAIT_DATA) && sdram_ready && !gnt) p0_rdata <= sdram_rdata[15:0];
            if ((state == ST_WAIT_DATA) && sdram_ready && gnt)  p1_rdata <= sdram_rdata[15:0];
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench: a round-robin instance (a_*) and a fixed-priority
// instance (b_*) share all inputs; expected values are hand-computed.
module tb_sdram_arbiter;

    logic        cpu_clk = 1'b0;
    logic        rst;
    logic        p0_read, p0_write, p1_read, p1_write;
    logic [22:0] p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic        sdram_busy, sdram_ready, sdram_cack;
    logic [31:0] sdram_rdata;

    logic [15:0] a_p0_rdata, a_p1_rdata, b_p0_rdata, b_p1_rdata;
    logic        a_p0_busy, a_p0_ready, a_p0_cack, a_p1_busy, a_p1_ready, a_p1_cack;
    logic        b_p0_busy, b_p0_ready, b_p0_cack, b_p1_busy, b_p1_ready, b_p1_cack;
    logic        a_sdram_read, a_sdram_write, b_sdram_read, b_sdram_write;
    logic [22:0] a_sdram_addr, b_sdram_addr;
    logic [15:0] a_sdram_wdata, b_sdram_wdata;
    logic        a_err_timeout, b_err_timeout;

    int vectors = 0;
    int miscompares = 0;

    always #5 cpu_clk = ~cpu_clk;

    sdram_arbiter #(.RR_EN(1'b1), .TIMEOUT(8'd10)) u_rr (
        .cpu_clk(cpu_clk), .rst(rst),
        .p0_read(p0_read), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(a_p0_rdata), .p0_busy(a_p0_busy), .p0_ready(a_p0_ready), .p0_cack(a_p0_cack),
        .p1_read(p1_read), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(a_p1_rdata), .p1_busy(a_p1_busy), .p1_ready(a_p1_ready), .p1_cack(a_p1_cack),
        .sdram_read(a_sdram_read), .sdram_write(a_sdram_write),
        .sdram_addr(a_sdram_addr), .sdram_wdata(a_sdram_wdata),
        .sdram_busy(sdram_busy), .sdram_ready(sdram_ready), .sdram_cack(sdram_cack),
        .sdram_rdata(sdram_rdata), .err_timeout(a_err_timeout)
    );

    sdram_arbiter #(.RR_EN(1'b0), .TIMEOUT(8'd10)) u_fp (
        .cpu_clk(cpu_clk), .rst(rst),
        .p0_read(p0_read), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(b_p0_rdata), .p0_busy(b_p0_busy), .p0_ready(b_p0_ready), .p0_cack(b_p0_cack),
        .p1_read(p1_read), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(b_p1_rdata), .p1_busy(b_p1_busy), .p1_ready(b_p1_ready), .p1_cack(b_p1_cack),
        .sdram_read(b_sdram_read), .sdram_write(b_sdram_write),
        .sdram_addr(b_sdram_addr), .sdram_wdata(b_sdram_wdata),
        .sdram_busy(sdram_busy), .sdram_ready(sdram_ready), .sdram_cack(sdram_cack),
        .sdram_rdata(sdram_rdata), .err_timeout(b_err_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge; inputs are driven here.
    task automatic nxt();
        @(posedge cpu_clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int cnt_w, cnt_pb, cnt_ck, early;

        rst = 1'b1;
        p0_read = 1'b0; p0_write = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_read = 1'b0; p1_write = 1'b0; p1_addr = '0; p1_wdata = '0;
        sdram_busy = 1'b0; sdram_ready = 1'b0; sdram_cack = 1'b0; sdram_rdata = '0;
        nxt(); nxt();
        rst = 1'b0;
        #1;
        chk("rst_read",  a_sdram_read, 0);
        chk("rst_write", a_sdram_write, 0);
        chk("rst_addr",  a_sdram_addr, 0);
        chk("rst_rdata", a_p0_rdata, 0);
        chk("rst_err",   a_err_timeout, 0);
        chk("rst_busy",  a_p0_busy, 0);

        // p0 write, cack after three WAIT_ACK cycles
        nxt(); p0_write = 1'b1; p0_addr = 23'h004c00; p0_wdata = 16'hBEEF; #1;
        chk("t1_idle_p1_busy", a_p1_busy, 0);
        cnt_w = 0; cnt_pb = 0; cnt_ck = 0;
        for (int i = 0; i < 5; i++) begin
            nxt(); sdram_cack = (i == 4); #1;
            if (a_sdram_write) cnt_w++;
            if (a_p1_busy) cnt_pb++;
            if (a_p0_cack) cnt_ck++;
            if (i == 0) begin
                chk("t1_addr",  a_sdram_addr, 23'h004c00);
                chk("t1_wdata", a_sdram_wdata, 16'hBEEF);
            end
        end
        chk("t1_write_cycles", cnt_w, 4);
        chk("t1_p1_busy_cycles", cnt_pb, 5);
        chk("t1_p0_cack_pulses", cnt_ck, 1);
        nxt(); sdram_cack = 1'b0; p0_write = 1'b0; #1;
        chk("t1_after_write", a_sdram_write, 0);
        chk("t1_after_p1_busy", a_p1_busy, 0);
        chk("t1_after_cack", a_p0_cack, 0);

        // p1 read
        nxt(); p1_read = 1'b1; p1_addr = 23'h005000; #1;
        nxt(); #1;
        chk("t2_issue_read", a_sdram_read, 1);
        chk("t2_addr", a_sdram_addr, 23'h005000);
        chk("t2_p0_busy", a_p0_busy, 1);
        nxt(); sdram_cack = 1'b1; #1;
        chk("t2_read_drop", a_sdram_read, 0);
        chk("t2_p1_cack", a_p1_cack, 1);
        chk("t2_p0_cack", a_p0_cack, 0);
        nxt(); sdram_cack = 1'b0; p1_read = 1'b0; sdram_ready = 1'b1; sdram_rdata = 32'h0000_1234; #1;
        chk("t2_ready_early", a_p1_ready, 0);
        nxt(); sdram_ready = 1'b0; sdram_rdata = '0; #1;
        chk("t2_ready", a_p1_ready, 1);
        chk("t2_rdata", a_p1_rdata, 16'h1234);
        chk("t2_p0_rdata", a_p0_rdata, 0);
        nxt(); sdram_cack = 1'b1; #1;
        chk("t2_idle_cack0", a_p0_cack, 0);
        chk("t2_idle_cack1", a_p1_cack, 0);
        chk("t2_ready_end", a_p1_ready, 0);
        chk("t2_rdata_hold", a_p1_rdata, 16'h1234);
        nxt(); sdram_cack = 1'b0; #1;
        chk("t2_idle_no_cmd", a_sdram_read, 0);

        // reset while in WAIT_ACK
        nxt(); p0_write = 1'b1; p0_addr = 23'h000007; p0_wdata = 16'h0055; #1;
        nxt(); #1;
        nxt(); rst = 1'b1; #1;
        chk("t5_waitack_write", a_sdram_write, 1);
        nxt(); rst = 1'b0; p0_write = 1'b0; #1;
        chk("t5_write",  a_sdram_write, 0);
        chk("t5_addr",   a_sdram_addr, 0);
        chk("t5_wdata",  a_sdram_wdata, 0);
        chk("t5_cack",   a_p0_cack, 0);
        chk("t5_p1rd",   a_p1_rdata, 0);
        chk("t5_p1busy", a_p1_busy, 0);
        nxt(); #1;
        chk("t5_no_late_cack", a_p0_cack, 0);

        // both ports reading continuously
        nxt(); p0_read = 1'b1; p1_read = 1'b1; p0_addr = 23'h000100; p1_addr = 23'h000200; #1;
        for (int k = 0; k < 4; k++) begin
            nxt(); #1;
            chk("t3_rr_addr", a_sdram_addr, (k % 2 == 1) ? 23'h000200 : 23'h000100);
            chk("t3_fp_addr", b_sdram_addr, 23'h000100);
            nxt(); sdram_cack = 1'b1; #1;
            chk("t3_rr_p0_cack", a_p0_cack, (k % 2 == 0));
            chk("t3_rr_p1_cack", a_p1_cack, (k % 2 == 1));
            chk("t3_fp_p0_cack", b_p0_cack, 1);
            chk("t3_fp_p1_cack", b_p1_cack, 0);
            nxt(); sdram_cack = 1'b0; sdram_ready = 1'b1; sdram_rdata = 32'h0000_A000 + k; #1;
            nxt(); sdram_ready = 1'b0;
            if (k == 3) begin
                p0_read = 1'b0; p1_read = 1'b0;
            end
            #1;
            chk("t3_rr_p0_ready", a_p0_ready, (k % 2 == 0));
            chk("t3_rr_p1_ready", a_p1_ready, (k % 2 == 1));
            chk("t3_fp_p0_ready", b_p0_ready, 1);
        end
        chk("t3_rr_p0_rdata", a_p0_rdata, 16'hA002);
        chk("t3_rr_p1_rdata", a_p1_rdata, 16'hA003);
        chk("t3_fp_p0_rdata", b_p0_rdata, 16'hA003);
        chk("t3_fp_p1_rdata", b_p1_rdata, 16'h0000);

        // read whose data never arrives
        nxt(); p0_read = 1'b1; p0_addr = 23'h000300; #1;
        nxt(); #1;
        nxt(); sdram_cack = 1'b1; #1;
        chk("t4_cack", a_p0_cack, 1);
        nxt(); sdram_cack = 1'b0; p0_read = 1'b0;
        early = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) nxt();
            #1;
            if (a_err_timeout || a_p0_ready) early++;
        end
        chk("t4_early", early, 0);
        nxt(); #1;
        chk("t4_ready", a_p0_ready, 1);
        chk("t4_err", a_err_timeout, 1);
        chk("t4_rdata_kept", a_p0_rdata, 16'hA002);
        chk("t4_fp_rdata_kept", b_p0_rdata, 16'hA003);
        chk("t4_fp_err", b_err_timeout, 1);
        nxt(); #1;
        chk("t4_ready_end", a_p0_ready, 0);
        chk("t4_err_sticky", a_err_timeout, 1);

        // controller busy holds off the grant; read wins over write
        nxt(); sdram_busy = 1'b1; p0_read = 1'b1; p0_write = 1'b1; p0_addr = 23'h000009; p0_wdata = 16'h1111; #1;
        chk("t6_p0_busy", a_p0_busy, 1);
        cnt_w = 0;
        for (int i = 0; i < 3; i++) begin
            nxt(); #1;
            if (a_sdram_read || a_sdram_write) cnt_w++;
        end
        chk("t6_no_cmd_while_busy", cnt_w, 0);
        nxt(); sdram_busy = 1'b0; #1;
        chk("t6_idle_read", a_sdram_read, 0);
        chk("t6_idle_busy", a_p0_busy, 0);
        nxt(); #1;
        chk("t6_issue_read", a_sdram_read, 1);
        chk("t6_issue_write", a_sdram_write, 0);
        chk("t6_addr", a_sdram_addr, 23'h000009);
        nxt(); sdram_cack = 1'b1; #1;
        chk("t6_cack", a_p0_cack, 1);
        nxt(); sdram_cack = 1'b0; p0_read = 1'b0; p0_write = 1'b0; sdram_ready = 1'b1; sdram_rdata = 32'hFFFF_0042; #1;
        nxt(); sdram_ready = 1'b0; #1;
        chk("t6_ready", a_p0_ready, 1);
        chk("t6_rdata", a_p0_rdata, 16'h0042);

        // only reset clears the abort flag
        nxt(); rst = 1'b1; #1;
        nxt(); rst = 1'b0; #1;
        chk("t7_err_clear", a_err_timeout, 0);
        chk("t7_rdata_clear", a_p0_rdata, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
